// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a bank of seven-segment digits.
// Registered outputs; display data swaps only at the frame boundary.
module seg7_scan #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  blank,
  input  logic                  test,
  input  logic                  lz_suppress,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 10;

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_disp;
  logic [4*DIGITS-1:0]   r_pend;
  logic                  r_pend_v;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_phase;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_den;
  logic                  r_fd;

  logic                  w_tick_wrap;
  logic                  w_frame;
  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_hi_zero;
  logic                  w_acc;
  logic [6:0]            w_seg;
  logic [DIGITS-1:0]     w_den;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_frame     = w_tick_wrap && (r_idx == IDX_LAST);
  assign w_nib       = r_disp[{r_idx, 2'b00} +: 4];
  assign w_den       = ~(DIGITS'(1) << r_idx);

  // w_hi_zero[i]: this nibble and every one above it are zero
  always_comb begin
    w_hi_zero = '0;
    w_acc     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_acc        = w_acc & (r_disp[4*i +: 4] == 4'h0);
      w_hi_zero[i] = w_acc;
    end
  end

  always_comb begin
    w_seg = hex7(w_nib);
    if (blank)
      w_seg = 7'h7F;
    else if (test)
      w_seg = 7'h00;
    else if (r_phase && blink_mask[r_idx])
      w_seg = 7'h7F;
    else if (lz_suppress && (r_idx != '0) && w_hi_zero[r_idx])
      w_seg = 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick      <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_seg       <= 7'h7F;
      r_den       <= '1;
      r_fd        <= 1'b0;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
      if (w_tick_wrap)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

      // a load landing on the boundary itself bypasses the pending slot
      if (w_frame) begin
        if (load)
          r_disp <= data;
        else if (r_pend_v)
          r_disp <= r_pend;
        r_pend_v <= 1'b0;
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end else if (load) begin
        r_pend   <= data;
        r_pend_v <= 1'b1;
      end

      r_seg <= w_seg;
      r_den <= w_den;
      r_fd  <= w_frame;
    end
  end

  assign segments   = r_seg;
  assign digit_en   = r_den;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: cycle scoreboard plus table-driven frame checks.
// DIGITS=4, DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BF     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        blank = 1'b0;
  logic        test = 1'b0;
  logic        lz = 1'b0;
  logic [3:0]  mask = '0;
  logic [6:0]  seg;
  logic [3:0]  den;
  logic        fd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data),
    .blank(blank), .test(test), .lz_suppress(lz),
    .blink_mask(mask), .segments(seg), .digit_en(den),
    .frame_done(fd)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] den;
    logic       fd;
  } obs_t;

  obs_t sb[$];

  logic [6:0] dec [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          m_tick, m_idx, m_bc;
  logic [15:0] m_disp, m_pend;
  logic        m_pv, m_ph;

  task automatic model_step();
    obs_t e;
    logic [15:0] hi;
    logic fr;
    if (reset) begin
      m_tick = 0; m_idx = 0; m_bc = 0;
      m_disp = '0; m_pend = '0; m_pv = 0; m_ph = 0;
      e.seg = 7'h7F; e.den = 4'hF; e.fd = 1'b0;
    end else begin
      fr = (m_tick == DIV - 1) && (m_idx == DIGITS - 1);
      hi = m_disp >> (4 * m_idx);
      if (blank) e.seg = 7'h7F;
      else if (test) e.seg = 7'h00;
      else if (m_ph && mask[m_idx]) e.seg = 7'h7F;
      else if (lz && m_idx != 0 && hi == 16'h0) e.seg = 7'h7F;
      else e.seg = dec[hi[3:0]];
      e.den = ~(4'h1 << m_idx);
      e.fd = fr;
      if (fr) begin
        if (load) m_disp = data;
        else if (m_pv) m_disp = m_pend;
        m_pv = 0;
        if (m_bc == BF - 1) begin m_bc = 0; m_ph = ~m_ph; end
        else m_bc++;
      end else if (load) begin
        m_pend = data; m_pv = 1;
      end
      if (m_tick == DIV - 1) begin
        m_tick = 0; m_idx = (m_idx + 1) % DIGITS;
      end else m_tick++;
    end
    sb.push_back(e);
  endtask

  task automatic sb_check();
    obs_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({seg, den, fd} !== {e.seg, e.den, e.fd}) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t: got seg=%h den=%b fd=%b expected seg=%h den=%b fd=%b",
                 $time, seg, den, fd, e.seg, e.den, e.fd);
      end
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) sb_check();

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd !== 1'b1 && n < 40);
    chk("frame_done seen", {15'h0, fd}, 16'h1);
  endtask

  task automatic read_frame(output logic [3:0][6:0] s);
    logic [3:0] e;
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 1 : 4) @(negedge clk);
      s[d] = seg;
      e = ~(4'h1 << d);
      chk($sformatf("digit_en d%0d", d), {12'h0, den}, {12'h0, e});
    end
  endtask

  typedef struct {
    logic [15:0]     d1;
    logic            two;
    logic [15:0]     d2;
    logic            lz;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t       vt [7];
  logic [6:0] prev3 = 7'h40;

  task automatic apply_vec(input vec_t v, input int id);
    logic [3:0][6:0] s;
    wait_fd();
    repeat (3) @(negedge clk);
    data = v.d1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (v.two) begin
      data = v.d2; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (8) @(negedge clk);
    end else begin
      repeat (9) @(negedge clk);
    end
    chk($sformatf("vec%0d old frame digit3", id), {9'h0, seg}, {9'h0, prev3});
    lz = v.lz;
    wait_fd();
    read_frame(s);
    for (int d = 0; d < 4; d++)
      chk($sformatf("vec%0d digit%0d", id, d), {9'h0, s[d]}, {9'h0, v.exp[d]});
    prev3 = v.exp[3];
  endtask

  initial begin
    logic [3:0][6:0] s;
    logic [6:0] b0 [8];
    logic [3:0] dl [4];
    int n;

    vt[0] = '{16'h1234, 1'b0, 16'h0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[1] = '{16'hAAAA, 1'b1, 16'h00F0, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}};
    vt[2] = '{16'h0105, 1'b0, 16'h0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h12}};
    vt[3] = '{16'h6789, 1'b0, 16'h0000, 1'b0, {7'h02, 7'h78, 7'h00, 7'h18}};
    vt[4] = '{16'hFEDC, 1'b0, 16'h0000, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vt[5] = '{16'h5AB0, 1'b0, 16'h0000, 1'b1, {7'h12, 7'h08, 7'h03, 7'h40}};
    vt[6] = '{16'h0000, 1'b0, 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};

    repeat (3) @(negedge clk);
    chk("reset seg", {9'h0, seg}, 16'h007F);
    chk("reset den", {12'h0, den}, 16'h000F);
    chk("reset fd", {15'h0, fd}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("release den", {12'h0, den}, 16'h000E);
    chk("release seg", {9'h0, seg}, 16'h0040);

    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd !== 1'b1 && n < 40);
    chk("frame period", 16'(n), 16'd16);
    @(negedge clk);
    chk("frame_done one cycle", {15'h0, fd}, 16'h0000);

    for (int i = 0; i < 7; i++) apply_vec(vt[i], i);

    // load exactly in the boundary cycle
    wait_fd();
    repeat (15) @(negedge clk);
    data = 16'hBEEF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("beef fd", {15'h0, fd}, 16'h0001);
    read_frame(s);
    chk("beef d0", {9'h0, s[0]}, 16'h000E);
    chk("beef d1", {9'h0, s[1]}, 16'h0006);
    chk("beef d2", {9'h0, s[2]}, 16'h0006);
    chk("beef d3", {9'h0, s[3]}, 16'h0003);
    prev3 = 7'h03;

    apply_vec('{16'h0008, 1'b0, 16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h00}}, 7);
    mask = 4'b0001;
    for (int f = 0; f < 8; f++) begin
      wait_fd();
      read_frame(s);
      b0[f] = s[0];
      chk("blink digit1", {9'h0, s[1]}, 16'h0040);
      chk("blink digit3", {9'h0, s[3]}, 16'h0040);
      chk("blink level", {15'h0, (s[0] == 7'h00 || s[0] == 7'h7F)}, 16'h1);
    end
    for (int f = 0; f < 6; f++)
      chk("blink half period", {15'h0, (b0[f] != b0[f + 2])}, 16'h1);
    mask = 4'b0000;

    blank = 1'b1; test = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("blank seg", {9'h0, seg}, 16'h007F);
      dl[k] = den;
      chk("blank den onehot", 16'($countones(~den)), 16'd1);
      if (k > 0) chk("blank den scans", {15'h0, (dl[k] != dl[k - 1])}, 16'h1);
      repeat (4) @(negedge clk);
    end
    blank = 1'b0;
    repeat (2) @(negedge clk);
    chk("test seg", {9'h0, seg}, 16'h0000);
    test = 1'b0;

    // reset mid-frame drops a pending load
    wait_fd();
    repeat (3) @(negedge clk);
    data = 16'h1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset seg", {9'h0, seg}, 16'h007F);
    chk("midreset den", {12'h0, den}, 16'h000F);
    chk("midreset fd", {15'h0, fd}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("rerelease den", {12'h0, den}, 16'h000E);
    chk("rerelease seg", {9'h0, seg}, 16'h0040);
    wait_fd();
    read_frame(s);
    for (int d = 0; d < 4; d++)
      chk($sformatf("after reset d%0d", d), {9'h0, s[d]}, 16'h0040);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for a bank of DIGITS seven-segment digits sharing one active-low segment bus.
- Successor to the single-digit hex decoder. Adds:
  - a parametrised digit count;
  - a refresh scan counter;
  - frame-synchronous (tear-free) data update;
  - leading-zero suppression and per-digit blink.
- Sits between the processor-facing register interface and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; 2..8.
- DIV, 50000: clocks each digit stays enabled per frame; 2..2^20.
- BLINK_FRAMES, 64: frames per blink half-period; 1..1023.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- load  in  1  capture data this cycle
- data  in  4*DIGITS  hex nibbles; [3:0] = digit 0 (least significant)
- blank  in  1  all digits dark
- test  in  1  lamp test, all segments lit on every scanned digit
- lz_suppress  in  1  blank leading zero digits
- blink_mask  in  DIGITS  per-digit blink enable
- segments  out  7  active-low; [0]=a … [6]=g
- digit_en  out  DIGITS  active-low one-hot digit select
- frame_done  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset values:
  - tick=0, idx=0, disp=0, pend=0, pend_v=0, blink_cnt=0, phase=0.
  - segments=7'h7F, digit_en all 1, frame_done=0.
- Reset mid-frame aborts the scan immediately and discards any pending data.
- Tick counter: counts 0..DIV-1 and wraps.
  - At tick==DIV-1, idx advances: idx+1, or 0 after DIGITS-1.
- Frame boundary (F): the cycle where tick==DIV-1 and idx==DIGITS-1. In cycle F:
  - frame_done pulses (registered; visible the cycle after F).
  - If load is high: disp<=data (bypass), pend_v<=0.
  - Else if pend_v: disp<=pend, pend_v<=0.
  - blink_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and phase toggles.
- Load outside F: pend<=data, pend_v<=1. A later load overwrites pend; the last value wins.
- Outputs are registered. segments/digit_en reflect the state of the previous cycle (1-clock latency).
- digit_en: bit idx = 0, all other bits = 1. It scans during blank and test as well.
- segments for digit idx with nibble n, in priority order:
  1. blank → 7'h7F
  2. test → 7'h00
  3. phase=1 and blink_mask[idx] → 7'h7F
  4. lz_suppress and idx≠0 and every nibble at index ≥ idx is 0 → 7'h7F
  5. otherwise hex decode of n.
- Hex decode table (n → segments):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→18, A→08, b→03, C→46, d→21, E→06, F→0E
- Digit 0 is never leading-zero blanked; a value of 0 shows "0".
- blank/test/lz_suppress/blink_mask are not latched. They are sampled every cycle.

Test Plan:
- DIGITS=4, DIV=4, BLINK_FRAMES=2 for all scenarios.
- Reset, then release → the cycle after release shows digit_en=4'b1110, segments=7'h40. digit_en steps 1101, 1011, 0111 every 4 clocks. frame_done pulses once per 16 clocks.
- Load data=16'h1234 mid-frame → current frame still shows 0000. Next frame shows: digit0 7'h19 (4), digit1 7'h30 (3), digit2 7'h24 (2), digit3 7'h79 (1).
- Two loads in one frame (16'hAAAA, then 16'h00F0) with lz_suppress=1 → next frame shows digit0 7'h40, digit1 7'h0E, digit2 dark, digit3 dark.
- Load asserted exactly in cycle F with data=16'hBEEF → the following frame displays b,E,E,F immediately, with no extra frame of delay.
- blink_mask=4'b0001, data=16'h0008 → digit0 shows 7'h00 for 2 frames, 7'h7F for 2 frames, repeating. Digits 1–3 are unaffected.
- blank=1 with test=1 → segments=7'h7F and digit_en keeps scanning. Reset pulsed mid-frame → outputs return to the reset values and display reverts to 0000.
